// File: rtl/router_pkg.sv
// Shared types and constants for the router output-lane receivers.
package router_pkg;

    localparam int unsigned ROUTER_PORTS = 16;
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned STAT_W       = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    // One buffered byte plus its packet-boundary markers.
    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic              last;
        logic              short;
    } rx_entry_t;

endpackage

// File: rtl/router_port_rx_if.sv
// Router lane input plus byte-side valid/ready output of one receiver.
interface router_port_rx_if;

    logic                          din;
    logic                          valid_n;
    logic                          frame_n;
    logic [router_pkg::BYTE_W-1:0] byte_o;
    logic                          last_o;
    logic                          short_o;
    logic                          byte_valid;
    logic                          byte_ready;

    // Receiver side.
    modport slave (
        input  din, valid_n, frame_n, byte_ready,
        output byte_o, last_o, short_o, byte_valid
    );

    // Lane driver / byte consumer side.
    modport master (
        output din, valid_n, frame_n, byte_ready,
        input  byte_o, last_o, short_o, byte_valid
    );

endinterface

// File: rtl/router_rx_fifo.sv
// Synchronous FIFO of rx entries; push while full is accepted only with a same-cycle pop.
module router_rx_fifo
    import router_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset_n,
    input  logic      push,
    input  logic      pop,
    input  rx_entry_t din,
    output rx_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    rx_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Occupancy after this edge.
    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage, pointers and registered full/empty flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/router_port_rx.sv
// Router lane receiver: deserializes MSB-first bits into bytes and buffers them.
// Optional statistics counters are built when ROUTER_RX_STATS_EN is defined.
module router_port_rx
    import router_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LANE_ID = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    router_port_rx_if.slave   port_if,
    output logic              ovf,
    output logic [STAT_W-1:0] pkt_count,
    output logic [STAT_W-1:0] drop_count
);

    localparam int unsigned        BCNT_W   = $clog2(BYTE_W);
    localparam logic [BCNT_W-1:0]  LAST_BIT = BCNT_W'(BYTE_W - 1);

    // Reject unusable configurations at elaboration.
    if ((LANE_ID >= ROUTER_PORTS) || (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_cfg
        $error("router_port_rx: DEPTH must be a power of two >= 2 and LANE_ID < ROUTER_PORTS");
    end

    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [BYTE_W-1:0] sr;
    logic [BYTE_W-1:0] sr_shift_c;
    logic [BCNT_W-1:0] bit_cnt;
    logic              frame_n_q;
    logic              bit_c;
    logic              start_c;
    logic              push_c;
    logic              pop_c;
    logic              drop_c;
    logic              fifo_full;
    logic              fifo_empty;
    rx_entry_t         push_entry_c;
    rx_entry_t         head;

    assign bit_c      = !port_if.valid_n;
    // frame_n_q resets low so a packet already in flight is not mistaken for a start.
    assign start_c    = frame_n_q && !port_if.frame_n;
    assign sr_shift_c = {sr[BYTE_W-2:0], port_if.din};
    assign pop_c      = !fifo_empty && port_if.byte_ready;
    assign drop_c     = push_c && fifo_full && !pop_c;

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: open on a frame_n falling edge, close on the final bit.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_c) state_nxt = RECV;
            RECV:    if (bit_c && port_if.frame_n) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: push on a full byte or on the final bit, left-aligning partial bytes.
    always_comb begin
        push_c       = 1'b0;
        push_entry_c = '0;
        if ((state == RECV) && bit_c) begin
            if (port_if.frame_n) begin
                push_c             = 1'b1;
                push_entry_c.last  = 1'b1;
                push_entry_c.short = (bit_cnt != LAST_BIT);
            end else if (bit_cnt == LAST_BIT) begin
                push_c = 1'b1;
            end
        end
        push_entry_c.data = sr_shift_c << (LAST_BIT - bit_cnt);
    end

    // Shift register, bit counter and frame strobe history.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr        <= '0;
            bit_cnt   <= '0;
            frame_n_q <= 1'b0;
        end else begin
            frame_n_q <= port_if.frame_n;
            if (state == IDLE) begin
                if (start_c) begin
                    bit_cnt <= bit_c ? BCNT_W'(1) : '0;
                    if (bit_c) begin
                        sr <= sr_shift_c;
                    end
                end
            end else if (bit_c) begin
                sr      <= sr_shift_c;
                bit_cnt <= port_if.frame_n ? '0 : bit_cnt + BCNT_W'(1);
            end
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf <= 1'b0;
        end else if (drop_c) begin
            ovf <= 1'b1;
        end
    end

    router_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push_c),
        .pop     (pop_c),
        .din     (push_entry_c),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign port_if.byte_o     = head.data;
    assign port_if.last_o     = head.last;
    assign port_if.short_o    = head.short;
    assign port_if.byte_valid = !fifo_empty;

`ifdef ROUTER_RX_STATS_EN
    // Saturating packet and drop counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            if (push_c && push_entry_c.last && (pkt_count != '1)) begin
                pkt_count <= pkt_count + STAT_W'(1);
            end
            if (drop_c && (drop_count != '1)) begin
                drop_count <= drop_count + STAT_W'(1);
            end
        end
    end
`else
    assign pkt_count  = '0;
    assign drop_count = '0;
`endif

endmodule
